// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader.
// Provides the loader FSM state codes, the UART receiver bit-timing state codes
// and the default bit period (100 MHz clock, 115200 baud).
package uart_program_loader_pkg;

    // Loader FSM state codes (2-bit).
    typedef enum logic [1:0] {
        StHeader = 2'b00,
        StData   = 2'b01,
        StRun    = 2'b10,
        StError  = 2'b11
    } loader_state_e;

    // UART receiver bit-timing states.
    typedef enum logic [1:0] {
        UrxIdle  = 2'b00,
        UrxStart = 2'b01,
        UrxData  = 2'b10,
        UrxStop  = 2'b11
    } uart_rx_state_e;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk, reset_n   - system clock, asynchronous active-low reset
//   rx             - serial input, idle high, asynchronous to clk
//   rx_byte        - received byte, valid while byte_valid is high
//   byte_valid     - one-cycle pulse when a frame ends with a good stop bit
//   frame_error    - one-cycle pulse when the stop bit is sampled low
module uart_program_loader_uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]     sync_q;
    logic           prev_q;
    uart_rx_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;

    logic rx_s;
    logic fall;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= UrxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            UrxIdle: begin
                if (fall) begin
                    state_d = UrxStart;
                    cnt_d   = '0;
                end
            end
            UrxStart: begin
                // Re-check the start bit at its centre; a high line was a glitch.
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? UrxIdle : UrxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UrxData: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = UrxStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UrxStop: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    state_d = UrxIdle;
                    valid_d = rx_s;
                    ferr_d  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UrxIdle;
        endcase
    end

    assign rx_byte     = shift_q;
    assign byte_valid  = valid_q;
    assign frame_error = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time program loader: receives an image over UART and writes it into
// instruction ROM, holding the CPU in reset until the image is complete.
// Image: 4-byte little-endian word count N, then N little-endian 32-bit words.
// Ports:
//   clk, reset_n       - system clock, asynchronous active-low reset
//   rx                 - UART serial input (8N1, idle high)
//   rom_wren           - one-cycle ROM write strobe
//   rom_write_address  - byte address of the word being written (word k at k*4)
//   rom_write_data     - instruction word being written
//   cpu_reset_n        - 0 holds the core in reset, 1 releases it
//   loading            - high while receiving header or data
//   error              - sticky error flag (framing error or oversized image)
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT         = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned ROM_ADDRESS_BITWIDTH = 14
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rx,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_write_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            loading,
    output logic                            error
);

    // One extra bit so a full-capacity count is representable.
    localparam int unsigned WcW      = ROM_ADDRESS_BITWIDTH - 1;
    localparam logic [31:0] Capacity = 32'(2 ** (ROM_ADDRESS_BITWIDTH - 2));

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_error;

    uart_program_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_error(frame_error)
    );

    loader_state_e                   state_q, state_d;
    logic [1:0]                      byte_cnt_q, byte_cnt_d;
    logic [23:0]                     shift_q, shift_d;
    logic [WcW-1:0]                  word_cnt_q, word_cnt_d;
    logic [WcW-1:0]                  n_q, n_d;
    logic                            wren_q, wren_d;
    logic [ROM_ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
    logic [31:0]                     data_q, data_d;
    logic                            cpu_rst_n_q;
    logic                            loading_q;
    logic                            error_q;

    logic [31:0] word;
    logic        active;

    // The 4th byte completes the word together with the three stored bytes.
    assign word   = {rx_byte, shift_q};
    assign active = (state_q == StHeader) || (state_q == StData);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StHeader;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            word_cnt_q  <= '0;
            n_q         <= '0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            loading_q   <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            word_cnt_q  <= word_cnt_d;
            n_q         <= n_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            // Lags the RUN state by one cycle so release follows the final strobe.
            cpu_rst_n_q <= (state_q == StRun);
            loading_q   <= (state_d == StHeader) || (state_d == StData);
            error_q     <= (state_d == StError);
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (active) begin
            if (frame_error) begin
                state_d = StError;
            end else if (byte_valid) begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                case (byte_cnt_q)
                    2'd0:    shift_d[7:0]   = rx_byte;
                    2'd1:    shift_d[15:8]  = rx_byte;
                    2'd2:    shift_d[23:16] = rx_byte;
                    default: ;
                endcase
                if (byte_cnt_q == 2'd3) begin
                    if (state_q == StHeader) begin
                        if (word == 32'd0) begin
                            state_d = StRun;
                        end else if (word > Capacity) begin
                            state_d = StError;
                        end else begin
                            state_d    = StData;
                            n_d        = word[WcW-1:0];
                            word_cnt_d = '0;
                        end
                    end else begin
                        wren_d     = 1'b1;
                        data_d     = word;
                        addr_d     = {word_cnt_q[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_d == n_q) begin
                            state_d = StRun;
                        end
                    end
                end
            end
        end
    end

    assign rom_wren          = wren_q;
    assign rom_write_address = addr_q;
    assign rom_write_data    = data_q;
    assign cpu_reset_n       = cpu_rst_n_q;
    assign loading           = loading_q;
    assign error             = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

    localparam int CPB = 16;
    localparam int AW  = 6;
    localparam int CAP = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic          rom_wren;
    logic [AW-1:0] rom_write_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          loading;
    logic          error;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ROM_ADDRESS_BITWIDTH(AW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx               (rx),
        .rom_wren         (rom_wren),
        .rom_write_address(rom_write_address),
        .rom_write_data   (rom_write_data),
        .cpu_reset_n      (cpu_reset_n),
        .loading          (loading),
        .error            (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } strobe_t;

    strobe_t     exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_strobe_cyc = -1;
    int          rise_cyc = -1;
    int          last_byte_start = 0;
    int          seen_n = 0;
    int unsigned seen_addr[0:31];
    logic [31:0] seen_data[0:31];
    logic [31:0] img[0:31];
    bit          exp_run, exp_err, exp_load;
    logic        prev_wren = 1'b0;
    logic        prev_cpu = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Per-cycle compare process against the expected strobe queue.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            prev_wren       <= 1'b0;
            prev_cpu        <= 1'b0;
            rise_cyc        <= -1;
            last_strobe_cyc <= -1;
            seen_n          <= 0;
        end else begin
            check(int'(loading) + int'(error) + int'(cpu_reset_n) <= 1, "status_exclusive",
                  {loading, error, cpu_reset_n}, 0);
            if (rom_wren) begin
                check(!prev_wren, "wren_back_to_back", 1, 0);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_strobe", rom_write_address, 0);
                end else begin
                    strobe_t s;
                    s = exp_q.pop_front();
                    check(rom_write_address == AW'(s.addr), "strobe_addr", rom_write_address,
                          s.addr);
                    check(rom_write_data == s.data, "strobe_data", rom_write_data, s.data);
                end
                if (seen_n < 32) begin
                    seen_addr[seen_n] <= rom_write_address;
                    seen_data[seen_n] <= rom_write_data;
                end
                seen_n          <= seen_n + 1;
                last_strobe_cyc <= cyc;
            end
            if (cpu_reset_n && !prev_cpu) rise_cyc <= cyc;
            prev_wren <= rom_wren;
            prev_cpu  <= cpu_reset_n;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        last_byte_start = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(0, 6)) @(negedge clk);
    endtask

    // Reference model: what the image must do, from the format rules alone.
    task automatic model_image(input int n, input int nwords, input int bad);
        exp_run = 0;
        exp_err = 0;
        if (bad >= 0 && bad < 4) exp_err = 1;
        else if (n == 0) exp_run = 1;
        else if (n > CAP) exp_err = 1;
        else begin
            for (int k = 0; k < n && k < nwords; k++) begin
                if (bad < 0 || 4 + 4 * k + 3 < bad) begin
                    strobe_t s;
                    s.addr = k * 4;
                    s.data = img[k];
                    exp_q.push_back(s);
                end
            end
            if (bad >= 0 && bad < 4 + 4 * n) exp_err = 1;
            else if (nwords >= n) exp_run = 1;
        end
        exp_load = !exp_run && !exp_err;
    endtask

    task automatic send_image(input int n, input int nwords, input int bad);
        logic [31:0] hdr;
        logic [31:0] w;
        int          hdr_last_start;
        hdr = n;
        model_image(n, nwords, bad);
        for (int j = 0; j < 4; j++) send_byte(hdr[8*j+:8], j != bad);
        hdr_last_start = last_byte_start;
        for (int k = 0; k < nwords; k++) begin
            w = img[k];
            for (int j = 0; j < 4; j++) send_byte(w[8*j+:8], (4 + 4 * k + j) != bad);
        end
        repeat (3 * CPB) @(negedge clk);
        check(exp_q.size() == 0, "missing_strobes", exp_q.size(), 0);
        check(cpu_reset_n == exp_run, "cpu_reset_n", cpu_reset_n, exp_run);
        check(error == exp_err, "error", error, exp_err);
        check(loading == exp_load, "loading", loading, exp_load);
        if (exp_run && n > 0)
            check(rise_cyc - last_strobe_cyc == 1, "release_delay", rise_cyc - last_strobe_cyc, 1);
        if (exp_run && n == 0)
            check(rise_cyc >= hdr_last_start + 150 && rise_cyc <= hdr_last_start + 165,
                  "release_after_header", rise_cyc - hdr_last_start, 157);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_random(input int cnt);
        for (int k = 0; k < cnt; k++) img[k] = $urandom();
    endtask

    initial begin
        int n;
        int bad;
        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check(rom_wren == 1'b0, "rst_wren", rom_wren, 0);
        check(rom_write_address == '0, "rst_addr", rom_write_address, 0);
        check(rom_write_data == 32'd0, "rst_data", rom_write_data, 0);
        check(cpu_reset_n == 1'b0, "rst_cpu", cpu_reset_n, 0);
        check(loading == 1'b1, "rst_loading", loading, 1);
        check(error == 1'b0, "rst_error", error, 0);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        check(cpu_reset_n == 1'b0 && loading == 1'b1 && error == 1'b0, "idle_1000",
              {cpu_reset_n, loading, error}, 3'b010);
        check(seen_n == 0, "idle_no_strobe", seen_n, 0);

        // N=2 with fixed words.
        img[0] = 32'h0050_0093;
        img[1] = 32'hDEAD_BEEF;
        send_image(2, 2, -1);
        check(seen_n == 2, "n2_count", seen_n, 2);
        check(seen_addr[0] == 0 && seen_data[0] == 32'h0050_0093, "n2_first", seen_data[0],
              32'h0050_0093);
        check(seen_addr[1] == 4 && seen_data[1] == 32'hDEAD_BEEF, "n2_second", seen_data[1],
              32'hDEAD_BEEF);

        // N=0.
        do_reset();
        send_image(0, 0, -1);
        check(cpu_reset_n == 1'b1 && seen_n == 0, "n0_run", {cpu_reset_n, seen_n[3:0]}, 5'h10);

        // N=17 exceeds capacity; following words must not be written.
        do_reset();
        fill_random(4);
        send_image(17, 4, -1);
        check(error == 1'b1 && cpu_reset_n == 1'b0, "n17_error", {error, cpu_reset_n}, 2'b10);

        // Full capacity, then extra bytes.
        do_reset();
        fill_random(16);
        send_image(16, 16, -1);
        check(seen_n == 16 && seen_addr[15] == 32'h3C, "n16_last_addr", seen_addr[15], 32'h3C);
        for (int j = 0; j < 8; j++) send_byte(8'($urandom()), 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check(seen_n == 16 && cpu_reset_n == 1'b1, "n16_extra_ignored", seen_n, 16);

        // Framing error at word 1 byte 2.
        do_reset();
        fill_random(3);
        send_image(3, 3, 10);
        check(seen_n == 1 && error == 1'b1, "frame_err_one_strobe", seen_n, 1);

        // Short start-bit glitch, then a one-word image.
        do_reset();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        fill_random(1);
        send_image(1, 1, -1);

        // Partial image, then reset in the middle of a byte.
        do_reset();
        fill_random(4);
        send_image(4, 2, -1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check(rom_wren == 1'b0 && cpu_reset_n == 1'b0 && loading == 1'b1 && error == 1'b0,
              "async_reset_values", {rom_wren, cpu_reset_n, loading, error}, 4'b0010);
        check(rom_write_address == '0 && rom_write_data == 32'd0, "async_reset_rom",
              rom_write_data, 0);
        @(negedge clk);
        do_reset();
        fill_random(3);
        send_image(3, 3, -1);

        // Randomized images, with and without a framing error.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 8);
            fill_random(n);
            send_image(n, n, -1);
        end
        for (int r = 0; r < 2; r++) begin
            do_reset();
            n = $urandom_range(2, 5);
            bad = $urandom_range(0, 4 + 4 * n - 1);
            fill_random(n);
            send_image(n, n, bad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
